// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for a 2-input combinational gate: walks the four
// input vectors, samples Z after a settle window and reports per-vector errors.
module gate_vector_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] tt,
  input  logic       z_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] tt_q, tt_d;
  logic [3:0] err_mask_q, err_mask_d;
  logic [2:0] err_count_q, err_count_d;
  logic       pass_q, pass_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state logic; the drive/status outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tt_d        = tt_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tt_d        = tt;
          err_mask_d  = 4'b0000;
          err_count_d = 3'd0;
          pass_d      = 1'b0;
          idx_d       = 2'd0;
          cnt_d       = 4'd0;
          state_d     = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (z_in != tt_q[idx_q]) begin
          err_mask_d[idx_q] = 1'b1;
          err_count_d       = err_count_q + 3'd1;
        end else begin
          err_mask_d = err_mask_q;
        end
        // pass must include a mismatch caught on this final sample
        if (idx_q == 2'd3) begin
          pass_d  = (err_mask_d == 4'b0000);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if ((state_d == ST_WAIT) || (state_d == ST_SAMPLE)) begin
      a_d = idx_d[1];
      b_d = idx_d[0];
    end else begin
      a_d = 1'b0;
      b_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      tt_q        <= 4'b0000;
      err_mask_q  <= 4'b0000;
      err_count_q <= 3'd0;
      pass_q      <= 1'b0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tt_q        <= tt_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three instances (SETTLE 2, 1, 15) share stimulus;
// a run-position model predicts every output every cycle.
module tb_gate_vector_checker;

  localparam int NI = 3;

  function automatic int settle_of(input int n);
    return (n == 0) ? 2 : ((n == 1) ? 1 : 15);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [3:0] tt;
  logic [3:0] zt;   // truth table of the simulated gate under test

  logic       a_w[NI];
  logic       b_w[NI];
  logic       busy_w[NI];
  logic       done_w[NI];
  logic       pass_w[NI];
  logic [3:0] mask_w[NI];
  logic [2:0] cnt_w[NI];
  logic       z_w[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign z_w[g] = zt[{a_w[g], b_w[g]}];
    gate_vector_checker #(.SETTLE((g == 0) ? 2 : ((g == 1) ? 1 : 15))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .tt        (tt),
      .z_in      (z_w[g]),
      .a_out     (a_w[g]),
      .b_out     (b_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .pass      (pass_w[g]),
      .err_mask  (mask_w[g]),
      .err_count (cnt_w[g])
    );
  end

  // Model: mk = cycle number since the accepted start (0 = idle), run length L = 4*(SETTLE+1).
  int         mk[NI]    = '{0, 0, 0};
  logic [3:0] mmask[NI] = '{4'b0000, 4'b0000, 4'b0000};
  logic [3:0] mtt[NI]   = '{4'b0000, 4'b0000, 4'b0000};
  logic       mpass[NI] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    for (int n = 0; n < NI; n++) begin
      automatic int s1 = settle_of(n) + 1;
      automatic int len = 4 * s1;
      automatic int k = mk[n];
      automatic logic [3:0] m = mmask[n];
      automatic logic [3:0] t = mtt[n];
      automatic logic p = mpass[n];
      automatic int i;
      if (rst) begin
        k = 0; m = 4'b0000; p = 1'b0;
      end else if (k == 0) begin
        if (start) begin
          k = 1; m = 4'b0000; p = 1'b0; t = tt;
        end
      end else if (k == len + 1) begin
        k = 0;
      end else begin
        if (k % s1 == 0) begin
          i = k / s1 - 1;
          if (zt[i] != t[i]) m[i] = 1'b1;
        end
        if (k == len) p = (m == 4'b0000);
        k = k + 1;
      end
      mk[n]    <= k;
      mmask[n] <= m;
      mtt[n]   <= t;
      mpass[n] <= p;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [10:0] dut_vec(input int n);
    return {a_w[n], b_w[n], busy_w[n], done_w[n], pass_w[n], mask_w[n], cnt_w[n]};
  endfunction

  function automatic logic [10:0] model_vec(input int n);
    automatic int s1 = settle_of(n) + 1;
    automatic int len = 4 * s1;
    automatic int k = mk[n];
    automatic logic [1:0] v = 2'b00;
    if (k >= 1 && k <= len) v = 2'((k - 1) / s1);
    return {v, (k != 0), (k == len + 1), mpass[n], mmask[n], 3'($countones(mmask[n]))};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: compare every instance with the model mid-cycle, then advance past the next edge.
  task automatic step();
    @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      n_checks++;
      if (dut_vec(n) !== model_vec(n)) begin
        n_fail++;
        $display("FAIL cycle_cmp inst%0d: got %b expected %b {a,b,busy,done,pass,mask,cnt} (t=%0t)",
                 n, dut_vec(n), model_vec(n), $time);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int c);
    for (int j = 0; j < c; j++) step();
  endtask

  task automatic start_run(input logic [3:0] ttv, input logic [3:0] ztv);
    tt = ttv; zt = ztv; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tt = 4'b0000; zt = 4'b0000;
    @(posedge clk); #1;
    step();
    chk("reset_outputs", int'(dut_vec(0)), 0);
    rst = 1'b0;
    step();

    // AND gate, all instances
    start_run(4'b1000, 4'b1000);
    chk("and_c1_ab", int'({a_w[0], b_w[0]}), 0);
    chk("and_c1_busy", int'(busy_w[0]), 1);
    steps(3);
    chk("and_c4_ab", int'({a_w[0], b_w[0]}), 1);
    steps(5);
    chk("s1_done_edge8", int'(done_w[1]), 1);
    steps(3);
    chk("and_c12_done", int'(done_w[0]), 0);
    chk("and_c12_ab", int'({a_w[0], b_w[0]}), 3);
    step();
    chk("and_done_edge12", int'(done_w[0]), 1);
    chk("and_pass", int'(pass_w[0]), 1);
    chk("and_ab_zero_in_done", int'({a_w[0], b_w[0]}), 0);
    step();
    chk("and_busy_fall_edge13", int'(busy_w[0]), 0);
    steps(2);
    chk("s15_c16_ab", int'({a_w[2], b_w[2]}), 0);
    step();
    chk("s15_c17_ab", int'({a_w[2], b_w[2]}), 1);
    steps(48);
    chk("s15_done_edge64", int'(done_w[2]), 1);
    steps(4);

    // stuck-at-0 gate
    start_run(4'b1000, 4'b0000);
    steps(12);
    chk("sa0_mask", int'(mask_w[0]), 8);
    chk("sa0_count", int'(cnt_w[0]), 1);
    chk("sa0_pass", int'(pass_w[0]), 0);
    steps(56);

    // NOR good, then OR against NOR table
    start_run(4'b0001, 4'b0001);
    steps(12);
    chk("nor_pass", int'(pass_w[0]), 1);
    steps(56);
    start_run(4'b0001, 4'b1110);
    steps(12);
    chk("or_vs_nor_mask", int'(mask_w[0]), 15);
    chk("or_vs_nor_count", int'(cnt_w[0]), 4);
    steps(56);

    // restarts and tt change mid-run are ignored; start in done cycle ignored, next cycle accepted
    start_run(4'b1000, 4'b1000);
    steps(2);
    start = 1'b1; tt = 4'b0000;
    step();
    start = 1'b0;
    steps(3);
    start = 1'b1;
    step();
    start = 1'b0;
    steps(5);
    chk("restart_done_edge12", int'(done_w[0]), 1);
    chk("restart_pass", int'(pass_w[0]), 1);
    start = 1'b1;
    step();
    chk("start_in_done_ignored", int'(busy_w[0]), 0);
    step();
    chk("start_after_done_accepted", int'(busy_w[0]), 1);
    start = 1'b0;
    steps(70);

    // reset mid-run
    start_run(4'b1000, 4'b1000);
    steps(4);
    rst = 1'b1;
    step();
    chk("midrun_reset_outputs", int'(dut_vec(0)), 0);
    rst = 1'b0;
    steps(70);
    start_run(4'b1000, 4'b1000);
    steps(12);
    chk("post_reset_pass", int'(pass_w[0]), 1);
    steps(56);

    // randomized runs with stray starts, tt churn, gate flips and rare resets
    for (int r = 0; r < 12; r++) begin
      automatic logic [3:0] tv = 4'($urandom);
      start_run(tv, ($urandom_range(0, 1) == 0) ? tv : 4'($urandom));
      for (int c = 0; c < 70; c++) begin
        start = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) tt = 4'($urandom);
        if ($urandom_range(0, 29) == 0) zt = 4'($urandom);
        rst = ($urandom_range(0, 299) == 0);
        step();
      end
      start = 1'b0; rst = 1'b0;
      steps(70);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
